// File: rtl/rs_pkg.sv
// Shared field widths, the dispatch payload layout and the RS class one-hot
// codes for the decode-to-reservation-station interface.
package rs_pkg;
    localparam int INST_W  = 10;
    localparam int ROB_W   = 6;
    localparam int OPR_W   = 33;
    localparam int OFF_W   = 32;
    localparam int DC2RS_W = 114;

    // Field order matches dc2rs with inst in the MSBs.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ROB_W-1:0]  dest_rob;
        logic [OPR_W-1:0]  opr1;
        logic [OPR_W-1:0]  opr2;
        logic [OFF_W-1:0]  offset;
    } rs_entry_t;

    localparam logic [3:0] RS_ALU = 4'b1000;
    localparam logic [3:0] RS_BR  = 4'b0100;
    localparam logic [3:0] RS_LS  = 4'b0010;
    localparam logic [3:0] RS_FP  = 4'b0001;
endpackage

// File: rtl/rs_operand_capture.sv
// Compares one pending operand against the CDB and substitutes the broadcast
// value when the producing ROB tag matches.
module rs_operand_capture
    import rs_pkg::*;
(
    input  logic [OPR_W-1:0] opr,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [OPR_W-1:0] opr_next
);
    logic hit;

    // Bit 32 clear means the low bits carry a tag; the upper bits are don't-care.
    assign hit      = cdb_valid && !opr[OPR_W-1] && (opr[ROB_W-1:0] == cdb_tag);
    assign opr_next = hit ? {1'b1, cdb_data} : opr;
endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, wakes operands from
// the CDB and issues the lowest-index operand-complete entry.
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dc_valid,
    input  logic [DC2RS_W-1:0]   dc2rs,
    output logic                 full,
    input  logic                 cdb_valid,
    input  logic [ROB_W-1:0]     cdb_tag,
    input  logic [31:0]          cdb_data,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [INST_W-1:0]    ex_inst,
    output logic [ROB_W-1:0]     ex_dest_rob,
    output logic [31:0]          ex_opr1,
    output logic [31:0]          ex_opr2,
    output logic [OFF_W-1:0]     ex_offset
);
    rs_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready_vec;
    logic [OPR_W-1:0] wake_opr1 [DEPTH];
    logic [OPR_W-1:0] wake_opr2 [DEPTH];
    rs_entry_t        dc_entry;
    rs_entry_t        alloc_entry;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             do_alloc;
    logic             do_issue;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [DEPTH-1:0] v);
        lowest_set = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign dc_entry = dc2rs;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_operand_capture u_cap1 (
            .opr(entries[g].opr1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .opr_next(wake_opr1[g])
        );
        rs_operand_capture u_cap2 (
            .opr(entries[g].opr2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .opr_next(wake_opr2[g])
        );
        assign ready_vec[g] = busy[g] && entries[g].opr1[OPR_W-1] && entries[g].opr2[OPR_W-1];
    end

    // Same-cycle bypass so a dispatch never misses a broadcast it raced with.
    rs_operand_capture u_dc_cap1 (
        .opr(dc_entry.opr1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .opr_next(alloc_entry.opr1)
    );
    rs_operand_capture u_dc_cap2 (
        .opr(dc_entry.opr2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .opr_next(alloc_entry.opr2)
    );
    assign alloc_entry.inst     = dc_entry.inst;
    assign alloc_entry.dest_rob = dc_entry.dest_rob;
    assign alloc_entry.offset   = dc_entry.offset;

    assign full      = &busy;
    assign alloc_idx = lowest_set(~busy);
    assign sel_idx   = lowest_set(ready_vec);
    assign ex_valid  = |ready_vec;
    assign do_alloc  = dc_valid && !full;
    assign do_issue  = ex_valid && ex_ready;

    always_comb begin
        ex_inst     = '0;
        ex_dest_rob = '0;
        ex_opr1     = '0;
        ex_opr2     = '0;
        ex_offset   = '0;
        if (ex_valid) begin
            ex_inst     = entries[sel_idx].inst;
            ex_dest_rob = entries[sel_idx].dest_rob;
            ex_opr1     = entries[sel_idx].opr1[31:0];
            ex_opr2     = entries[sel_idx].opr2[31:0];
            ex_offset   = entries[sel_idx].offset;
        end
    end

    // Issue clears a busy slot and allocation fills a free one, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    entries[i].opr1 <= wake_opr1[i];
                    entries[i].opr2 <= wake_opr2[i];
                end
            end
            if (do_issue) busy[sel_idx] <= 1'b0;
            if (do_alloc) begin
                busy[alloc_idx]    <= 1'b1;
                entries[alloc_idx] <= alloc_entry;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(dc_valid && full))
        else $error("reservation_station: dc_valid asserted while full");
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the decode→RS dispatch bus (dc2rs, 114 bits).
- One instance per functional-unit class, selected by the matching rs_dest one-hot bit: ALU, branch, load/store or FP.
- Holds DEPTH pending instructions and captures missing operands from the common data bus (CDB).
- Issues one operand-complete instruction per cycle to its functional unit over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..16).
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dc_valid  input  1  dispatch strobe; this RS's rs_dest bit ANDed with decode-valid.
- dc2rs  input  114  {inst[9:0], dest_rob[5:0], opr1[32:0], opr2[32:0], offset[31:0]}, inst in MSBs.
- full  output  1  no free entry; decode must not assert dc_valid while full is high.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  6  ROB tag of the broadcast result.
- cdb_data  input  32  broadcast result.
- flush  input  1  synchronous squash of all entries (mispredict).
- ex_valid  output  1  issue candidate present.
- ex_ready  input  1  functional unit accepts this cycle.
- ex_inst  output  10  issued instruction field.
- ex_dest_rob  output  6  destination ROB tag.
- ex_opr1, ex_opr2  output  32  operand values.
- ex_offset  output  32  offset / target field, passed through unchanged.

Behaviour:
- Operand encoding (33 bits): bit32=1 means bits[31:0] hold the value; bit32=0 means bits[5:0] hold the producing ROB tag and bits[31:6] are don't-care.
- Entry state: busy bit plus the 114-bit payload. Entry ready when busy and both operand bit32 are 1.
- Reset: all busy=0, payloads zero; full=0, ex_valid=0, all ex_* data outputs 0.
- Allocation: on dc_valid && !full, write dc2rs into the lowest-index non-busy entry and set busy. dc_valid while full is a protocol error: ignored, assertion fires in simulation.
- full = all entries busy, from registered state only. A slot freed by issue in cycle N is reusable from cycle N+1.
- Wakeup: on cdb_valid, every busy entry with opr bit32=0 and opr[5:0]==cdb_tag sets that operand to {1, cdb_data}. Both operands may match in the same cycle.
- Dispatch/CDB bypass: if an incoming dc2rs operand is pending and matches cdb_tag in the same cycle, the entry is written already-valid with cdb_data.
- Selection: lowest-index ready entry, computed combinationally from registered state. An entry woken in cycle N is issuable in cycle N+1; there is no CDB→issue bypass.
- Issue outputs: ex_valid=1 when any entry is ready. ex_* are driven from the selected entry (opr[31:0] only). When ex_valid=0, ex_* are all zero.
- Issue handshake: on ex_valid && ex_ready, the selected entry's busy clears at the clock edge. While ex_ready=0, the selection is stable unless a lower-index entry becomes ready; changing to that entry is permitted.
- Flush: clears all busy bits at the edge and overrides allocation, wakeup and issue in that cycle. ex_valid drops to 0 the next cycle.
- Latency: dispatch with both operands valid → ex_valid is 1 in the next cycle.
- Reset asserted mid-operation clears everything immediately (asynchronously).

Decomposition:
- Shared package rs_pkg holds:
  - field widths: INST_W=10, ROB_W=6, OPR_W=33, OFF_W=32, DC2RS_W=114;
  - typedef rs_entry_t (packed struct matching the dc2rs field order);
  - RS one-hot constants RS_ALU=4'b1000, RS_BR=4'b0100, RS_LS=4'b0010, RS_FP=4'b0001.
- One sub-module, rs_operand_capture: per-operand CDB compare-and-capture, instantiated twice per entry and twice on the dispatch bypass path.
- Priority pickers (lowest free, lowest ready) stay inline as functions.

Test Plan:
1. Reset, then dispatch inst=10'h000, dest_rob=3, opr1={1,32'd5}, opr2={1,32'd7}, offset=0 with ex_ready=1 → next cycle ex_valid=1, ex_opr1=5, ex_opr2=7, ex_dest_rob=3; the cycle after, ex_valid=0.
2. Dispatch opr1={0,tag 9}, opr2={1,32'd1}; CDB tag 9, data 32'hDEAD two cycles later → ex_valid=0 until the cycle after the CDB, then ex_opr1=32'hDEADBEEF-free value 32'h0000DEAD.
3. Dispatch with opr2 pending on tag 12 while the CDB broadcasts tag 12, data 42 in the same cycle → entry issues the next cycle with ex_opr2=42.
4. ex_ready=0, dispatch 4 ready entries → full=1 after the 4th. Raise ex_ready for one cycle → entry 0 issues, full=0 the next cycle, and a new dispatch lands in entry 0.
5. Fill 3 entries, assert flush together with dc_valid and a matching CDB → next cycle full=0, ex_valid=0, and no entry retained.
6. Assert rst asynchronously mid-cycle with 2 busy entries → ex_valid and full fall to 0 without waiting for a clk edge.
